// File: rtl/muldiv_unit_pkg.sv
// Shared types and op-classification helpers for the RV M-extension unit.
//   muldiv_op_t    : funct3 encoding of the eight M-extension operations
//   muldiv_state_t : control FSM states of muldiv_unit
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_rs1(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_rs2(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per clock.
//   clk, rstn  : clock, asynchronous active-low reset
//   start      : load dividend/divisor and begin XLEN iterations
//   abort      : drop the current division
//   dividend   : unsigned dividend (sampled on start)
//   divisor    : unsigned, non-zero divisor (sampled on start)
//   quotient   : quotient, valid while done=1
//   remainder  : remainder, valid while done=1
//   done       : high for the one cycle after the last iteration
module div_core
#(
  parameter int XLEN = 32
)
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            done
);

  localparam int CW = $clog2(XLEN + 1);

  logic            active_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic [XLEN:0]   trial;
  logic            fits;
  logic [XLEN-1:0] diff;

  // Partial remainder shifted left with the next dividend bit; quo_q doubles
  // as the dividend shift register and fills with quotient bits from the right.
  assign trial = {rem_q, quo_q[XLEN-1]};
  assign fits  = (trial >= {1'b0, dvsr_q});
  // When fits=1 the difference is below the divisor, so XLEN bits suffice.
  assign diff  = trial[XLEN-1:0] - dvsr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
    end else if (abort) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(XLEN);
      quo_q    <= dividend;
      rem_q    <= '0;
      dvsr_q   <= divisor;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        quo_q <= {quo_q[XLEN-2:0], fits};
        rem_q <= fits ? diff : trial[XLEN-1:0];
        cnt_q <= cnt_q - CW'(1);
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  assign done      = active_q & (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV M-extension unit: pipelined multiplier plus iterative divider.
//   clk, rstn  : clock, asynchronous active-low reset
//   enabled    : issue strobe, taken only while busy=0 and flush=0
//   op         : muldiv_op_t (funct3 encoding)
//   rs1, rs2   : operands, latched on the accepting edge
//   flush      : abort the in-flight operation (no completion)
//   busy       : operation in flight
//   completed  : one-cycle pulse, result valid
//   result     : last completed result, held until the next completion
//
// state   | meaning
// --------+----------------------------------------------------------------
// ST_IDLE | waiting for issue; also the state during the completion cycle
// ST_MUL  | product travelling down the stage chain, cnt_q = stage 1..N
// ST_DIV  | divider iterating / sign-fix, or a divide special case pending
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
)
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            enabled,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            completed,
  output logic [XLEN-1:0] result
);

  localparam int              CW   = $clog2(MUL_STAGES + 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_n;
  muldiv_op_t      op_in, op_q;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            completed_n;
  logic [XLEN-1:0] result_n;
  logic            accept;

  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div0, ovf, special;
  logic [XLEN-1:0] spec_val;

  logic            spec_q;
  logic [XLEN-1:0] spec_res_q;
  logic            q_neg_q, r_neg_q;

  logic [2*XLEN-1:0] mul_a, mul_b;
  logic [2*XLEN-1:0] prod_pipe [MUL_STAGES];
  logic [XLEN-1:0]   mul_res, div_res;

  logic            div_start, div_abort, div_done;
  logic [XLEN-1:0] div_quo, div_rem;

  assign op_in  = muldiv_op_t'(op);
  assign busy   = (state_q != ST_IDLE);
  assign accept = enabled & ~busy & ~flush;

  // Operand signs and magnitudes; unsigned ops see neg=0 and pass through.
  assign neg1 = is_signed_rs1(op_in) & rs1[XLEN-1];
  assign neg2 = is_signed_rs2(op_in) & rs2[XLEN-1];
  assign mag1 = neg1 ? -rs1 : rs1;
  assign mag2 = neg2 ? -rs2 : rs2;

  assign div0     = (rs2 == '0);
  assign ovf      = is_signed_rs2(op_in) & (rs1 == SMIN) & (rs2 == '1);
  assign special  = is_div(op_in) & (div0 | ovf);
  assign spec_val = div0 ? (is_rem(op_in) ? rs1 : '1)
                         : (is_rem(op_in) ? '0  : rs1);

  assign div_start = accept & is_div(op_in) & ~special;
  assign div_abort = flush & busy;

  // Sign-extend to 2*XLEN: the truncated 2*XLEN-bit product is then exact
  // for every signedness combination.
  assign mul_a = {{XLEN{neg1}}, rs1};
  assign mul_b = {{XLEN{neg2}}, rs2};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q       <= OP_MUL;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
    end else if (accept) begin
      op_q       <= op_in;
      spec_q     <= special;
      spec_res_q <= spec_val;
      q_neg_q    <= neg1 ^ neg2;
      r_neg_q    <= neg1;
    end
  end

  // Product shift chain; stages after the multiplier are free for retiming.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MUL_STAGES; i++) prod_pipe[i] <= '0;
    end else begin
      if (accept && !is_div(op_in)) prod_pipe[0] <= mul_a * mul_b;
      for (int i = 1; i < MUL_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  assign mul_res = (op_q == OP_MUL) ? prod_pipe[MUL_STAGES-1][XLEN-1:0]
                                    : prod_pipe[MUL_STAGES-1][2*XLEN-1:XLEN];
  assign div_res = is_rem(op_q) ? (r_neg_q ? -div_rem : div_rem)
                                : (q_neg_q ? -div_quo : div_quo);

  div_core #(.XLEN(XLEN)) u_div_core (
    .clk       (clk),
    .rstn      (rstn),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    completed_n = 1'b0;
    result_n    = result;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_div(op_in)) begin
            state_n = ST_DIV;
          end else begin
            state_n = ST_MUL;
            cnt_n   = CW'(1);
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == CW'(MUL_STAGES)) begin
          state_n     = ST_IDLE;
          cnt_n       = '0;
          completed_n = 1'b1;
          result_n    = mul_res;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else if (spec_q) begin
          state_n     = ST_IDLE;
          completed_n = 1'b1;
          result_n    = spec_res_q;
        end else if (div_done) begin
          state_n     = ST_IDLE;
          completed_n = 1'b1;
          result_n    = div_res;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      completed <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      completed <= completed_n;
      result    <= result_n;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: one instance at XLEN=32/MUL_STAGES=2 and
// one at XLEN=16/MUL_STAGES=3, each with its own driver, model and monitor.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] val;
    int          done;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit fin0 = 1'b0;
  bit fin1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int            X    = (g == 0) ? 32 : 16;
    localparam int            S    = (g == 0) ? 2 : 3;
    localparam logic [X-1:0]  ONES = '1;
    localparam logic [X-1:0]  SMIN = {1'b1, {(X-1){1'b0}}};

    logic         rstn, enabled, flush, busy, completed;
    logic [2:0]   op;
    logic [X-1:0] rs1, rs2, result;

    muldiv_unit #(.XLEN(X), .MUL_STAGES(S)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .enabled   (enabled),
      .op        (op),
      .rs1       (rs1),
      .rs2       (rs2),
      .flush     (flush),
      .busy      (busy),
      .completed (completed),
      .result    (result)
    );

    exp_t         q[$];
    exp_t         popped;
    exp_t         pushed;
    int           busy_to = 0;
    logic [X-1:0] last_res = '0;
    bit           mon_en = 1'b0;
    logic [2:0]   ro;
    logic [X-1:0] ra, rb;

    task automatic ck(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk($sformatf("X%0d/%s", X, tag), got, exp);
    endtask

    function automatic logic [X-1:0] ref_model(input logic [2:0] o, input logic [X-1:0] a,
                                              input logic [X-1:0] b);
      longint      sa, sb, sp;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = 64'(a);
      ub = 64'(b);
      p  = '0;
      case (o)
        3'd0: p = ua * ub;
        3'd1: begin sp = sa * sb;             p = 64'(sp) >> X; end
        3'd2: begin sp = sa * longint'(ub);   p = 64'(sp) >> X; end
        3'd3: p = (ua * ub) >> X;
        3'd4: begin
          if (b == '0) p = 64'(ONES);
          else if (a == SMIN && b == ONES) p = 64'(a);
          else begin sp = sa / sb; p = 64'(sp); end
        end
        3'd5: p = (b == '0) ? 64'(ONES) : ua / ub;
        3'd6: begin
          if (b == '0) p = 64'(a);
          else if (a == SMIN && b == ONES) p = '0;
          else begin sp = sa % sb; p = 64'(sp); end
        end
        default: p = (b == '0) ? 64'(a) : ua % ub;
      endcase
      return p[X-1:0];
    endfunction

    function automatic int lat(input logic [2:0] o, input logic [X-1:0] a, input logic [X-1:0] b);
      if (!o[2]) return S;
      if (b == '0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == SMIN && b == ONES) return 1;
      return X + 1;
    endfunction

    task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
    endtask

    // kind 0: accepted and tracked; 1: accepted but discarded later; 2: must be ignored
    task automatic issue(input logic [2:0] o, input logic [X-1:0] a, input logic [X-1:0] b,
                         input int kind);
      int e0;
      op = o; rs1 = a; rs2 = b; enabled = 1'b1;
      @(posedge clk); #1;
      enabled = 1'b0;
      op  = 3'($urandom);
      rs1 = X'($urandom);
      rs2 = X'($urandom);
      e0  = edges;
      if (kind == 0) begin
        pushed.val  = 32'(ref_model(o, a, b));
        pushed.done = e0 + lat(o, a, b);
        q.push_back(pushed);
        busy_to = e0 + lat(o, a, b);
      end else if (kind == 1) begin
        busy_to = e0 + lat(o, a, b);
      end
    endtask

    task automatic wait_idle();
      while (edges < busy_to) begin @(posedge clk); #1; end
    endtask

    task automatic run(input logic [2:0] o, input logic [X-1:0] a, input logic [X-1:0] b);
      issue(o, a, b, 0);
      wait_idle();
    endtask

    always @(negedge clk) begin
      if (!rstn) begin
        last_res = '0;
        q.delete();
      end else if (mon_en) begin
        ck("busy", 32'(busy), 32'(edges < busy_to));
        if (completed) begin
          if (q.size() == 0) begin
            ck("spurious_completed", 32'(1), 32'(0));
          end else begin
            popped = q.pop_front();
            ck("result", 32'(result), popped.val);
            ck("done_edge", 32'(edges), 32'(popped.done));
            last_res = popped.val[X-1:0];
          end
        end else if (q.size() != 0 && edges >= q[0].done) begin
          ck("missing_completed", 32'(0), 32'(1));
          void'(q.pop_front());
        end
      end
    end

    initial begin
      rstn = 1'b0; enabled = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0;
      #2;
      ck("reset_busy", 32'(busy), 32'(0));
      ck("reset_completed", 32'(completed), 32'(0));
      ck("reset_result", 32'(result), 32'(0));
      step(3);
      rstn = 1'b1;
      mon_en = 1'b1;

      // multiply high halves and corner operands
      run(3'd1, SMIN, SMIN);
      run(3'd3, ONES, ONES);
      run(3'd2, ONES, ONES);
      run(3'd0, ONES, ONES);
      run(3'd0, X'($urandom), X'($urandom));
      run(3'd2, SMIN, ONES);

      // iterative divide, signed and unsigned
      run(3'd4, X'(-7), X'(2));
      run(3'd6, X'(-7), X'(2));
      run(3'd5, X'(100), X'(7));
      run(3'd7, X'(100), X'(7));
      run(3'd4, X'(7), X'(-2));
      run(3'd6, X'(-7), X'(-2));

      // special cases complete one edge after accept
      run(3'd5, X'($urandom), '0);
      run(3'd6, X'(5), '0);
      run(3'd4, SMIN, ONES);
      run(3'd6, SMIN, ONES);
      run(3'd4, X'(-9), '0);
      run(3'd7, X'(9), '0);
      run(3'd5, SMIN, ONES);

      // reset in the middle of a divide
      issue(3'd4, X'(1000), X'(3), 1);
      step(5);
      busy_to = edges;
      #1 rstn = 1'b0;
      #1;
      ck("midrst_busy", 32'(busy), 32'(0));
      ck("midrst_completed", 32'(completed), 32'(0));
      ck("midrst_result", 32'(result), 32'(0));
      @(posedge clk); #1;
      rstn = 1'b1;
      step(X + 4);

      // flush a divide at E0+10, with a colliding enabled
      run(3'd0, X'(3), X'(5));
      issue(3'd4, X'(12345), X'(7), 1);
      step(9);
      flush = 1'b1; enabled = 1'b1; op = 3'd0;
      @(posedge clk); #1;
      flush = 1'b0; enabled = 1'b0;
      busy_to = edges;
      ck("flush_div_result", 32'(result), 32'(last_res));
      run(3'd0, X'(11), X'(13));

      // flush a multiply before it completes
      issue(3'd3, ONES, X'(3), 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      busy_to = edges;
      ck("flush_mul_result", 32'(result), 32'(last_res));
      step(S + 2);

      // flush together with enabled while idle: nothing accepted
      flush = 1'b1;
      issue(3'd0, X'(2), X'(2), 2);
      flush = 1'b0;
      step(S + 2);
      ck("idle_flush_result", 32'(result), 32'(last_res));

      // back-to-back issue in the completion cycle
      issue(3'd0, X'(6), X'(7), 0);   wait_idle();
      issue(3'd1, SMIN, X'(3), 0);    wait_idle();
      issue(3'd4, X'(-100), X'(9), 0); wait_idle();
      issue(3'd6, SMIN, ONES, 0);     wait_idle();
      issue(3'd2, X'(-5), X'(5), 0);  wait_idle();
      step(1);

      // enabled while busy is ignored
      issue(3'd5, X'(1000), X'(33), 0);
      repeat (4) issue(3'd0, X'($urandom), X'($urandom), 2);
      enabled = 1'b1; op = 3'd1;
      step(5);
      enabled = 1'b0;
      wait_idle();
      issue(3'd1, X'(-3), X'(5), 0);
      issue(3'd0, X'(9), X'(9), 2);
      wait_idle();

      // random mix
      for (int i = 0; i < 20; i++) begin
        ro = 3'($urandom);
        ra = ($urandom_range(0, 5) == 0) ? SMIN : X'($urandom);
        rb = ($urandom_range(0, 6) == 0) ? '0 :
             ($urandom_range(0, 6) == 0) ? ONES : X'($urandom);
        issue(ro, ra, rb, 0);
        wait_idle();
        if ($urandom_range(0, 1) == 1) step(1);
      end

      step(X + 4);
      ck("queue_drained", 32'(q.size()), 32'(0));
      if (g == 0) fin0 = 1'b1;
      else        fin1 = 1'b1;
    end
  end

  initial begin
    fork
      wait (fin0 && fin1);
      #300000;
    join_any
    disable fork;
    if (!(fin0 && fin1)) chk("timeout", 32'(0), 32'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV M-extension unit; successor to the single-cycle combinational mul/div path in the execute ALU.
- Pipelined multiplier with configurable latency; iterative radix-2 restoring divider.
- Sits beside the ALU in execute; core issues on `enabled`, stalls on `busy`, and writes back on the `completed` pulse.

Parameters:
- XLEN, 32, operand/result width (≥8, even).
- MUL_STAGES, 2, multiply latency in cycles (≥1).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enabled  in  1  issue strobe; accepted only when busy=0
- op  in  3  muldiv_op_t (funct3 encoding: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu)
- rs1  in  XLEN  operand 1 (dividend / multiplicand)
- rs2  in  XLEN  operand 2 (divisor / multiplier)
- flush  in  1  synchronous abort of the in-flight op
- busy  out  1  op in flight; further issue ignored
- completed  out  1  one-cycle pulse, result valid
- result  out  XLEN  result; held until the next completion

Behaviour:

Reset:
- rstn low clears state asynchronously: FSM=IDLE, busy=0, completed=0, result=0, counters=0.
- Reset mid-operation discards the op with no completion.

Accept:
- Accept edge E0 = rising edge with enabled=1, busy=0, flush=0.
- op, rs1 and rs2 are latched at E0; inputs are ignored afterwards.

FSM states:
- IDLE: on accept, go to MUL for op<4, else DIV. Divide special cases go straight to DONE.
- MUL: stage counter runs 1..MUL_STAGES. Completion at E0+MUL_STAGES.
- DIV: XLEN iterations, one quotient bit per edge (E1..E_XLEN), then one sign-fix edge E_XLEN+1.
- DONE: not a held state. Completion is a registered pulse, and the FSM returns to IDLE on the completing edge.

Handshake:
- busy=1 from after E0 up to the completing edge; busy=0 in the cycle completed=1.
- Back-to-back issue in the completion cycle is legal and is accepted.
- completed=1 for exactly one cycle per accepted, unflushed op.

Multiply arithmetic (2·XLEN-bit product):
- mul: low XLEN bits.
- mulh: signed×signed, high half.
- mulhsu: signed rs1 × unsigned rs2, high half.
- mulhu: unsigned×unsigned, high half.

Divide arithmetic:
- Operands are converted to magnitudes for signed ops. Quotient sign = rs1[msb]^rs2[msb]; remainder sign = rs1[msb].
- Special cases are decided at E0 and complete at E0+1 without iterating:
  - divisor 0: div/divu result all-ones; rem/remu result rs1.
  - signed overflow (rs1 = 1<<(XLEN-1), rs2 = all-ones): div result rs1; rem result 0.
- Unsigned ops skip sign handling but still take the sign-fix cycle (fixed latency XLEN+1).

Flush:
- flush=1 at any edge with busy=1: FSM→IDLE, busy=0, no completion, result unchanged.
- flush with enabled in the same cycle: flush wins and nothing is accepted.
- flush when idle: no effect.

Decomposition:
- def.sv: muldiv_op_t enum (3-bit, values above), muldiv_state_t {IDLE, MUL, DIV}, and localparam-style helpers for op classification (is_div, is_signed_rs1, is_signed_rs2).
- Sub-module div_core (XLEN param): unsigned restoring iterator with start, quotient, remainder and done.
- The multiplier is inline as a product register shift chain of depth MUL_STAGES, for retiming.

Test Plan:
1. Reset low mid-div, release: busy=0, completed=0, result=0; no later pulse.
2. mulh rs1=0x80000000, rs2=0x80000000 → completed at E0+2, result=0x40000000; mulhu rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFE; mulhsu rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF.
3. div rs1=-7 (0xFFFFFFF9), rs2=2 → completed at E0+33, result 0xFFFFFFFD; rem → 0xFFFFFFFF; divu 100/7 → 14; remu → 2.
4. divu x/0 → 0xFFFFFFFF at E0+1; rem 5/0 → 5; div 0x80000000/0xFFFFFFFF → 0x80000000; rem of same → 0.
5. Issue div, assert flush at E0+10 → busy=0 next cycle, no completed, result unchanged; a new mul issued the following cycle completes normally.
6. Back-to-back: mul issued in the cycle completed=1 is accepted; enabled while busy is ignored (exactly one pulse per accept). Repeat with XLEN=16, MUL_STAGES=3.
